snn_mlp_engine: RTL

- Parametrised two-layer MLP inference engine, successor to the fixed 784-32-10 SNN core.
- Streams a binary input image from the external input RAM and runs N_IN x N_HID then N_HID x N_OUT MACs with LUT activation.
- Holds hidden activations in an internal RAM and reports the argmax output index with a start/done handshake.
- Weight ROMs and the activation LUT sit outside the block behind 1-cycle-latency synchronous read ports.

---
 rtl/snn_pkg.sv | 30 +++
 rtl/snn_mlp_engine_mac.sv | 32 +++
 rtl/snn_mlp_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the two-layer MLP inference engine.
package snn_pkg;

    localparam int N_IN_DEF   = 784;
    localparam int N_HID_DEF  = 32;
    localparam int N_OUT_DEF  = 10;
    localparam int DW_DEF     = 8;
    localparam int ACC_W_DEF  = 26;
    localparam int LUT_AW_DEF = 11;

    // Rectified accumulator slice is offset so the most negative value lands on LUT entry 0.
    localparam logic [10:0] LUT_OFFSET = 11'h400;
    localparam logic [10:0] S_POS_SAT  = 11'h3FF;
    localparam logic [10:0] S_NEG_SAT  = 11'h400;
    localparam logic [7:0]  PIX_ONE    = 8'h7F;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        H_MAC   = 4'd1,
        H_DRAIN = 4'd2,
        H_ACT   = 4'd3,
        H_WR    = 4'd4,
        O_MAC   = 4'd5,
        O_DRAIN = 4'd6,
        O_ACT   = 4'd7,
        O_CMP   = 4'd8,
        DONE    = 4'd9
    } state_t;

endpackage

// File: rtl/snn_mlp_engine_mac.sv
// Signed multiply-accumulate with synchronous clear (priority over enable) and async reset.
module snn_mac #(
    parameter int AW    = 9,
    parameter int BW    = 8,
    parameter int ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [AW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [AW+BW-1:0]  w_prod;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod = a * b;
    assign acc    = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/snn_mlp_engine.sv
// Two-layer MLP inference engine: streams binary pixels, runs hidden and output MAC layers
// through an external activation LUT and reports the argmax. Optional macro SNN_SCORE_OUT_EN adds max_score.
module snn_mlp_engine
    import snn_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_HID  = N_HID_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DW     = DW_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF,
    localparam int IW    = $clog2(N_IN),
    localparam int HW    = $clog2(N_HID),
    localparam int OW    = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              q_input,
    output logic [IW-1:0]     in_addr,
    output logic [HW+IW-1:0]  hid_w_addr,
    input  logic [DW-1:0]     hid_w_q,
    output logic [OW+HW-1:0]  out_w_addr,
    input  logic [DW-1:0]     out_w_q,
    output logic [LUT_AW-1:0] act_addr,
    input  logic [DW-1:0]     act_q,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state,
    output logic [OW-1:0]     digit
`ifdef SNN_SCORE_OUT_EN
    ,
    output logic [DW-1:0]     max_score
`endif
);

    state_t r_state, w_state_next;

    logic [IW-1:0]     r_in_idx;
    logic [HW-1:0]     r_hid_idx;
    logic [OW-1:0]     r_out_idx;
    logic [1:0]        r_cnt;
    logic [LUT_AW-1:0] r_act_addr;
    logic [DW-1:0]     r_max;
    logic [OW-1:0]     r_digit;
    logic              r_busy, r_done;
    logic              r_h_vld, r_o_vld1, r_o_vld2;
    logic [DW-1:0]     r_opa, r_opb;
    logic [DW-1:0]     r_hid_ram [N_HID];
    logic [DW-1:0]     r_hid_rd;

    logic                    w_in_last, w_hid_last, w_out_last, w_drain_last;
    logic                    w_mac_en, w_mac_clr;
    logic [DW:0]             w_mac_a;
    logic [DW-1:0]           w_mac_b;
    logic signed [ACC_W-1:0] w_acc;
    logic [ACC_W-19:0]       w_upper;
    logic                    w_sat_pos, w_sat_neg;
    logic [10:0]             w_s;
    logic [10:0]             w_addr_sum;
    logic                    w_unused;

    assign w_in_last    = (r_in_idx == IW'(N_IN - 1));
    assign w_hid_last   = (r_hid_idx == HW'(N_HID - 1));
    assign w_out_last   = (r_out_idx == OW'(N_OUT - 1));
    // Output layer has one more drain cycle: registered hid_ram read feeds an operand register.
    assign w_drain_last = ((r_state == H_DRAIN) && (r_cnt == 2'd1)) ||
                          ((r_state == O_DRAIN) && (r_cnt == 2'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = H_MAC;
            H_MAC:   if (w_in_last) w_state_next = H_DRAIN;
            H_DRAIN: if (w_drain_last) w_state_next = H_ACT;
            H_ACT:   w_state_next = H_WR;
            H_WR:    w_state_next = w_hid_last ? O_MAC : H_MAC;
            O_MAC:   if (w_hid_last) w_state_next = O_DRAIN;
            O_DRAIN: if (w_drain_last) w_state_next = O_ACT;
            O_ACT:   w_state_next = O_CMP;
            O_CMP:   w_state_next = w_out_last ? DONE : O_MAC;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Hidden operand comes straight from the input RAM; output operands are pre-registered.
    assign w_mac_en  = r_h_vld | r_o_vld2;
    assign w_mac_clr = (r_state == H_WR) || (r_state == O_CMP);
    assign w_mac_a   = r_h_vld ? {1'b0, (q_input ? DW'(PIX_ONE) : DW'(0))} : {1'b0, r_opa};
    assign w_mac_b   = r_h_vld ? hid_w_q : r_opb;

    snn_mac #(
        .AW    (DW + 1),
        .BW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_mac_en),
        .clr   (w_mac_clr),
        .a     (w_mac_a),
        .b     (w_mac_b),
        .acc   (w_acc)
    );

    // Clamp the accumulator to the 11-bit window acc[17:7] before offsetting into the LUT.
    assign w_upper    = w_acc[ACC_W-2:17];
    assign w_sat_pos  = ~w_acc[ACC_W-1] & (|w_upper);
    assign w_sat_neg  = w_acc[ACC_W-1] & ~(&w_upper);
    assign w_s        = w_sat_pos ? S_POS_SAT : (w_sat_neg ? S_NEG_SAT : w_acc[17:7]);
    assign w_addr_sum = w_s + LUT_OFFSET;
    assign w_unused   = ^w_acc[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_idx   <= '0;
            r_hid_idx  <= '0;
            r_out_idx  <= '0;
            r_cnt      <= '0;
            r_act_addr <= '0;
            r_max      <= '0;
            r_digit    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_h_vld    <= 1'b0;
            r_o_vld1   <= 1'b0;
            r_o_vld2   <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
        end else begin
            r_busy   <= (w_state_next != IDLE) && (w_state_next != DONE);
            r_done   <= (w_state_next == DONE);
            r_h_vld  <= (r_state == H_MAC);
            r_o_vld1 <= (r_state == O_MAC);
            r_o_vld2 <= r_o_vld1;
            r_opa    <= r_hid_rd;
            r_opb    <= out_w_q;

            if (r_state == H_MAC)
                r_in_idx <= w_in_last ? '0 : r_in_idx + IW'(1);

            if ((r_state == H_DRAIN) || (r_state == O_DRAIN))
                r_cnt <= w_drain_last ? 2'd0 : r_cnt + 2'd1;

            if (w_drain_last)
                r_act_addr <= LUT_AW'(w_addr_sum);

            if ((r_state == H_WR) || (r_state == O_MAC))
                r_hid_idx <= w_hid_last ? '0 : r_hid_idx + HW'(1);

            if (r_state == O_CMP) begin
                // Strict compare keeps the lowest index on ties.
                if ((r_out_idx == '0) || (act_q > r_max)) begin
                    r_max   <= act_q;
                    r_digit <= r_out_idx;
                end
                r_out_idx <= w_out_last ? '0 : r_out_idx + OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == H_WR)
            r_hid_ram[r_hid_idx] <= act_q;
        r_hid_rd <= r_hid_ram[r_hid_idx];
    end

    assign in_addr    = r_in_idx;
    assign hid_w_addr = {r_hid_idx, r_in_idx};
    assign out_w_addr = {r_out_idx, r_hid_idx};
    assign act_addr   = r_act_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign digit      = r_digit;
    assign dbg_state  = r_state;

`ifdef SNN_SCORE_OUT_EN
    assign max_score = r_max;
`else
    // Without the score port the max register only feeds the argmax compare.
`endif

endmodule
